// File: rtl/led_pattern_writer_pkg.sv
// Shared encodings and sizes for the LED column pattern writer.
package led_pattern_writer_pkg;

    localparam int PAT_DEPTH = 32;
    localparam int PAT_WIDTH = 10;
    localparam int ADDR_W    = 5;
    localparam int LEN_W     = 6;

    typedef enum logic [1:0] {
        MODE_CLEAR = 2'b00,
        MODE_EDIT  = 2'b01,
        MODE_PLAY  = 2'b10
    } mode_t;

endpackage

// File: rtl/led_pattern_writer_if.sv
// Button/switch inputs and display/status outputs of the pattern writer.
interface led_pattern_writer_if;
    import led_pattern_writer_pkg::*;

    logic                 btn_wr;
    logic                 btn_mode;
    logic                 btn_clr;
    logic [PAT_WIDTH-1:0] sw;
    logic [PAT_WIDTH-1:0] led;
    logic [ADDR_W-1:0]    waddr;
    logic [LEN_W-1:0]     len;
    logic [1:0]           mode;
    logic                 full;

    modport master (
        output btn_wr, btn_mode, btn_clr, sw,
        input  led, waddr, len, mode, full
    );

    modport slave (
        input  btn_wr, btn_mode, btn_clr, sw,
        output led, waddr, len, mode, full
    );

endinterface

// File: rtl/led_pattern_writer_btn_pulse.sv
// Raw button -> 2-FF synchronizer -> debouncer -> one-cycle pulse on accepted press.
module btn_pulse #(
    parameter int DB_CYCLES = 8
) (
    input  logic msclk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // cnt counts down the remaining disagreeing cycles; any agreement reloads it
    always_ff @(posedge msclk or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= CNT_LOAD;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            pulse <= 1'b0;
            if (sync[1] == level) begin
                cnt <= CNT_LOAD;
            end else if (cnt == '0) begin
                level <= sync[1];
                cnt   <= CNT_LOAD;
                pulse <= sync[1];
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_writer.sv
// Records switch columns into a 32x10 pattern RAM and plays them back on the LEDs.
//   state      | meaning
//   MODE_CLEAR | sweep zeros into every RAM word, led dark, buttons ignored
//   MODE_EDIT  | led mirrors sw; wr stores sw at waddr
//   MODE_PLAY  | led steps through mem[0..len-1], PLAY_DIV cycles per column
module led_pattern_writer
    import led_pattern_writer_pkg::*;
#(
    parameter int DB_CYCLES = 8,
    parameter int PLAY_DIV  = 4
) (
    input  logic                 msclk,
    input  logic                 reset,
    led_pattern_writer_if.slave  bus
);
    localparam int DIV_W = (PLAY_DIV > 1) ? $clog2(PLAY_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PLAY_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PAT_DEPTH - 1);
    localparam logic [LEN_W-1:0]  LEN_FULL  = LEN_W'(PAT_DEPTH);

    logic wr_p, mode_p, clr_p;

    btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_wr   (.msclk(msclk), .reset(reset), .btn(bus.btn_wr),   .pulse(wr_p));
    btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_mode (.msclk(msclk), .reset(reset), .btn(bus.btn_mode), .pulse(mode_p));
    btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_clr  (.msclk(msclk), .reset(reset), .btn(bus.btn_clr),  .pulse(clr_p));

    logic [PAT_WIDTH-1:0] mem [PAT_DEPTH];

    mode_t                mode_q;
    logic [ADDR_W-1:0]    waddr;
    logic [ADDR_W-1:0]    raddr;
    logic [DIV_W-1:0]     div;
    logic [LEN_W-1:0]     len_q;
    logic [PAT_WIDTH-1:0] led_q;

    logic [LEN_W-1:0]     waddr_inc;
    logic [LEN_W-1:0]     len_post;
    logic                 mem_we;
    logic [PAT_WIDTH-1:0] mem_wd;

    // len after a same-cycle EDIT write, so a simultaneous mode press sees it
    always_comb begin
        waddr_inc = {1'b0, waddr} + 1'b1;
        len_post  = len_q;
        if (wr_p && (waddr_inc > len_q))
            len_post = waddr_inc;
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wd = bus.sw;
        case (mode_q)
            MODE_CLEAR: begin
                mem_we = 1'b1;
                mem_wd = '0;
            end
            MODE_EDIT:  mem_we = wr_p && !clr_p;
            default:    mem_we = 1'b0;
        endcase
    end

    always_ff @(posedge msclk) begin
        if (mem_we)
            mem[waddr] <= mem_wd;
    end

    always_ff @(posedge msclk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_CLEAR;
            waddr  <= '0;
            raddr  <= '0;
            div    <= '0;
            len_q  <= '0;
            led_q  <= '0;
        end else begin
            case (mode_q)
                MODE_CLEAR: begin
                    led_q <= '0;
                    if (waddr == ADDR_LAST) begin
                        waddr  <= '0;
                        len_q  <= '0;
                        mode_q <= MODE_EDIT;
                    end else begin
                        waddr <= waddr + 1'b1;
                    end
                end
                MODE_EDIT: begin
                    led_q <= bus.sw;
                    if (clr_p) begin
                        mode_q <= MODE_CLEAR;
                        waddr  <= '0;
                    end else begin
                        if (wr_p) begin
                            waddr <= waddr_inc[ADDR_W-1:0];
                            len_q <= len_post;
                        end
                        if (mode_p && (len_post != '0)) begin
                            mode_q <= MODE_PLAY;
                            raddr  <= '0;
                            div    <= '0;
                        end
                    end
                end
                MODE_PLAY: begin
                    led_q <= mem[raddr];
                    if (clr_p) begin
                        mode_q <= MODE_CLEAR;
                        waddr  <= '0;
                    end else if (mode_p) begin
                        mode_q <= MODE_EDIT;
                    end else if (div == DIV_LAST) begin
                        div   <= '0;
                        raddr <= ({1'b0, raddr} == (len_q - 1'b1)) ? '0 : raddr + 1'b1;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: mode_q <= MODE_CLEAR;
            endcase
        end
    end

    assign bus.led   = led_q;
    assign bus.waddr = waddr;
    assign bus.len   = len_q;
    assign bus.mode  = mode_q;
    assign bus.full  = (len_q == LEN_FULL);

endmodule

// File: tb/tb_led_pattern_writer.sv
// Directed bench for led_pattern_writer with DB_CYCLES=4, PLAY_DIV=4.
module tb_led_pattern_writer;
    import led_pattern_writer_pkg::*;

    localparam int BTN_WR   = 0;
    localparam int BTN_MODE = 1;
    localparam int BTN_CLR  = 2;

    logic msclk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   wr_count = 0;
    logic [1:0] last_mode = 2'b00;
    logic [4:0] last_waddr = 5'd0;

    led_pattern_writer_if bus ();

    led_pattern_writer #(.DB_CYCLES(4), .PLAY_DIV(4)) dut (
        .msclk (msclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 msclk = ~msclk;

    // writes seen as waddr steps while staying in EDIT
    always @(negedge msclk) begin
        if (last_mode == MODE_EDIT && bus.mode == MODE_EDIT && bus.waddr != last_waddr)
            wr_count++;
        last_mode  = bus.mode;
        last_waddr = bus.waddr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge msclk);
        #1;
    endtask

    task automatic set_btn(input int which, input logic val);
        case (which)
            BTN_WR:   bus.btn_wr   = val;
            BTN_MODE: bus.btn_mode = val;
            default:  bus.btn_clr  = val;
        endcase
    endtask

    task automatic press(input int which);
        set_btn(which, 1'b1);
        repeat (12) step();
        set_btn(which, 1'b0);
        repeat (12) step();
    endtask

    task automatic wait_mode(input logic [1:0] m, input int budget, input string tag);
        int n = 0;
        while (bus.mode !== m && n < budget) begin
            step();
            n++;
        end
        chk(tag, bus.mode, m);
    endtask

    task automatic count_clear(input string tag);
        int n = 0;
        int bad = 0;
        while (bus.mode === MODE_CLEAR && n < 100) begin
            if (bus.len !== 6'd0 || bus.led !== 10'd0) bad++;
            step();
            n++;
        end
        chk(tag, n, 32);
        chk({tag, "_dark"}, bad, 0);
        chk({tag, "_edit"}, bus.mode, MODE_EDIT);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0] pat [3];
        int w0;
        pat[0] = 10'h006;
        pat[1] = 10'h382;
        pat[2] = 10'h2BB;

        bus.btn_wr = 1'b0; bus.btn_mode = 1'b0; bus.btn_clr = 1'b0; bus.sw = 10'h000;
        #2 reset = 1'b1;
        #1;
        chk("rst_mode",  bus.mode,  MODE_CLEAR);
        chk("rst_waddr", bus.waddr, 0);
        chk("rst_len",   bus.len,   0);
        chk("rst_led",   bus.led,   0);
        chk("rst_full",  bus.full,  0);
        repeat (3) step();
        reset = 1'b0;
        count_clear("clear_cycles");

        // single clean write
        bus.sw = 10'h2AB;
        w0 = wr_count;
        press(BTN_WR);
        chk("one_write",  wr_count - w0, 1);
        chk("mem0",       dut.mem[0], 10'h2AB);
        chk("waddr_1",    bus.waddr, 1);
        chk("len_1",      bus.len, 1);
        chk("edit_led",   bus.led, 10'h2AB);

        // bouncing button yields a single write
        bus.sw = 10'h155;
        w0 = wr_count;
        for (int i = 0; i < 10; i++) begin
            bus.btn_wr = (i % 2 == 0);
            repeat (2) step();
        end
        bus.btn_wr = 1'b1;
        repeat (12) step();
        bus.btn_wr = 1'b0;
        repeat (12) step();
        chk("bounce_one_write", wr_count - w0, 1);
        chk("bounce_waddr", bus.waddr, 2);

        press(BTN_CLR);
        wait_mode(MODE_EDIT, 60, "clr_to_edit");
        chk("clr_waddr", bus.waddr, 0);
        chk("clr_len",   bus.len, 0);
        chk("clr_mem1",  dut.mem[1], 0);

        for (int i = 0; i < 3; i++) begin
            bus.sw = pat[i];
            press(BTN_WR);
        end
        chk("len_3", bus.len, 3);

        bus.btn_mode = 1'b1;
        wait_mode(MODE_PLAY, 30, "enter_play");
        for (int k = 0; k < 24; k++) begin
            step();
            chk("play_led", bus.led, pat[(k / 4) % 3]);
        end
        bus.btn_mode = 1'b0;
        repeat (12) step();

        bus.sw = 10'h111;
        press(BTN_WR);
        chk("play_wr_ignored", bus.waddr, 3);
        chk("play_len_kept",   bus.len, 3);

        press(BTN_MODE);
        chk("back_to_edit", bus.mode, MODE_EDIT);
        chk("edit_waddr",   bus.waddr, 3);
        chk("edit_mem1",    dut.mem[1], 10'h382);

        // fill and wrap
        press(BTN_CLR);
        wait_mode(MODE_EDIT, 60, "clr2_to_edit");
        bus.sw = 10'h3FF;
        for (int i = 1; i <= 33; i++) begin
            press(BTN_WR);
            if (i == 31) chk("full_31", bus.full, 0);
            if (i == 32) begin
                chk("full_32",  bus.full, 1);
                chk("len_32",   bus.len, 32);
                chk("waddr_32", bus.waddr, 0);
            end
            if (i == 33) begin
                chk("waddr_33", bus.waddr, 1);
                chk("len_33",   bus.len, 32);
                chk("full_33",  bus.full, 1);
            end
        end

        press(BTN_CLR);
        wait_mode(MODE_EDIT, 60, "clr3_to_edit");
        press(BTN_MODE);
        chk("mode_len0", bus.mode, MODE_EDIT);

        bus.sw = 10'h0F0;
        press(BTN_WR);
        bus.btn_mode = 1'b1;
        wait_mode(MODE_PLAY, 30, "enter_play2");
        bus.btn_mode = 1'b0;
        repeat (12) step();
        chk("len1_led", bus.led, 10'h0F0);
        bus.btn_clr  = 1'b1;
        bus.btn_mode = 1'b1;
        wait_mode(MODE_CLEAR, 30, "clr_beats_mode");
        bus.btn_clr  = 1'b0;
        bus.btn_mode = 1'b0;
        wait_mode(MODE_EDIT, 60, "clr4_to_edit");

        // reset in the middle of PLAY
        press(BTN_WR);
        bus.btn_mode = 1'b1;
        wait_mode(MODE_PLAY, 30, "enter_play3");
        bus.btn_mode = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        #1;
        chk("mid_rst_mode", bus.mode, MODE_CLEAR);
        chk("mid_rst_led",  bus.led, 0);
        chk("mid_rst_len",  bus.len, 0);
        step();
        reset = 1'b0;
        count_clear("reclear_cycles");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
